// File: rtl/light_seq_pkg.sv
// light_seq_pkg: shared definitions for the rotating one-hot light sequence
// (monitor and driver). Holds the FSM state encoding, the OFF position code
// and the successor rule of the rotation.
package light_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } seq_state_e;

    localparam int POS_OFF = 0;

    // Legal successor of position p in a rotation of n lights:
    // OFF -> 1, k -> k+1, last light wraps to 1 (never back to OFF).
    function automatic int seq_succ(input int p, input int n);
        if (p >= n) begin
            return 1;
        end else begin
            return p + 1;
        end
    endfunction

endpackage

// File: rtl/light_onehot_decoder.sv
// light_onehot_decoder: combinational decode of the light bus into a position
// index. All-zero gives OFF (0), a single bit k gives k+1, more than one lit
// bit is flagged as not legal (position value is then don't-care).
module light_onehot_decoder #(
    parameter int NUM_LIGHTS = 4,
    parameter int POS_W      = $clog2(NUM_LIGHTS + 1)
) (
    input  logic [NUM_LIGHTS-1:0] i_luces,
    output logic                  o_legal,
    output logic [POS_W-1:0]      o_pos
);

    // decode the lit bit to its 1-based index and flag multi-bit patterns
    always_comb begin
        o_pos   = {POS_W{1'b0}};
        o_legal = ($countones(i_luces) < 2);
        for (int i = 0; i < NUM_LIGHTS; i++) begin
            if (i_luces[i]) begin
                o_pos = POS_W'(i + 1);
            end else begin
                o_pos = o_pos;
            end
        end
    end

endmodule

// File: rtl/light_seq_monitor.sv
// light_seq_monitor: receive-side checker for the rotating one-hot light
// sequence OFF,L1..Ln,L1,... Tracks the last accepted position, flags illegal
// steps with a one-cycle seq_err pulse and keeps saturating lap/fault counts.
// All outputs are registered, one cycle behind the qualified sample.
// Build option: define SEQMON_HOLD_TOL_EN to accept a repeated position in
// TRACK as a legal dwell; by default a repeat is a sequence fault.
module light_seq_monitor
    import light_seq_pkg::*;
#(
    parameter int NUM_LIGHTS = 4,
    parameter int CNT_W      = 8,
    parameter int POS_W      = $clog2(NUM_LIGHTS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_en,
    input  logic [NUM_LIGHTS-1:0] luces,
    output logic [POS_W-1:0]      pos,
    output logic                  locked,
    output logic                  seq_err,
    output logic [CNT_W-1:0]      lap_count,
    output logic [CNT_W-1:0]      err_count
);

`ifdef SEQMON_HOLD_TOL_EN
    localparam bit HOLD_TOL = 1'b1;
`else
    localparam bit HOLD_TOL = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    seq_state_e         r_state;
    seq_state_e         w_state_nxt;
    logic [POS_W-1:0]   r_pos;
    logic [POS_W-1:0]   w_pos_nxt;
    logic               r_locked;
    logic               r_seq_err;
    logic [CNT_W-1:0]   r_lap_count;
    logic [CNT_W-1:0]   r_err_count;
    logic               w_legal;
    logic [POS_W-1:0]   w_dec;
    logic               w_fault_evt;
    logic               w_lap_evt;
    logic               w_is_succ;
    logic               w_is_repeat;

    light_onehot_decoder #(
        .NUM_LIGHTS (NUM_LIGHTS),
        .POS_W      (POS_W)
    ) u_decoder (
        .i_luces (luces),
        .o_legal (w_legal),
        .o_pos   (w_dec)
    );

    // classify the decoded sample relative to the last accepted position
    always_comb begin
        w_is_succ   = w_legal && (int'(w_dec) == seq_succ(int'(r_pos), NUM_LIGHTS));
        w_is_repeat = w_legal && (w_dec == r_pos);
    end

    // next-state, next-position and event decode; nothing moves unless sampled
    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_fault_evt = 1'b0;
        w_lap_evt   = 1'b0;
        if (sample_en) begin
            case (r_state)
                ST_TRACK: begin
                    if (w_is_succ) begin
                        w_pos_nxt = w_dec;
                        w_lap_evt = (int'(w_dec) == NUM_LIGHTS);
                    end else if (HOLD_TOL && w_is_repeat) begin
                        w_pos_nxt = r_pos;
                    end else begin
                        w_state_nxt = ST_FAULT;
                        w_fault_evt = 1'b1;
                    end
                end
                ST_FAULT: begin
                    // recovery only through OFF or the first light; other
                    // patterns keep us here silently
                    if (w_legal && (int'(w_dec) <= 1)) begin
                        w_state_nxt = ST_TRACK;
                        w_pos_nxt   = w_dec;
                    end else begin
                        w_state_nxt = ST_FAULT;
                    end
                end
                default: begin
                    // IDLE, and the unused encoding behaves as IDLE
                    if (w_legal) begin
                        w_state_nxt = ST_TRACK;
                        w_pos_nxt   = w_dec;
                    end else begin
                        w_state_nxt = ST_FAULT;
                        w_fault_evt = 1'b1;
                    end
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // state, position, status flags and saturating counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_pos       <= POS_W'(POS_OFF);
            r_locked    <= 1'b0;
            r_seq_err   <= 1'b0;
            r_lap_count <= {CNT_W{1'b0}};
            r_err_count <= {CNT_W{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_pos     <= w_pos_nxt;
            r_locked  <= (w_state_nxt == ST_TRACK);
            r_seq_err <= w_fault_evt;
            if (w_lap_evt && (r_lap_count != CNT_MAX)) begin
                r_lap_count <= r_lap_count + CNT_W'(1'b1);
            end
            if (w_fault_evt && (r_err_count != CNT_MAX)) begin
                r_err_count <= r_err_count + CNT_W'(1'b1);
            end
        end
    end

    assign pos       = r_pos;
    assign locked    = r_locked;
    assign seq_err   = r_seq_err;
    assign lap_count = r_lap_count;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_light_seq_monitor.sv
// tb_light_seq_monitor: directed scenarios followed by randomized stimulus,
// checked against a behavioural model of the light-sequence rules. Two
// instances share the inputs: default counters and 2-bit counters for
// saturation. Honours SEQMON_HOLD_TOL_EN like the design.
module tb_light_seq_monitor;

    localparam int N = 4;

    logic       clk;
    logic       rst;
    logic       sample_en;
    logic [3:0] luces;

    logic [2:0] pos_a, pos_b;
    logic       locked_a, locked_b, seq_err_a, seq_err_b;
    logic [7:0] lap_a, err_a;
    logic [1:0] lap_b, err_b;

    int total = 0;
    int bad   = 0;

    // behavioural model: mode 0 = waiting for first sample, 1 = following, 2 = faulted
    int m_mode  = 0;
    int m_pos   = 0;
    int m_laps  = 0;
    int m_errs  = 0;
    int m_pulse = 0;
`ifdef SEQMON_HOLD_TOL_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    light_seq_monitor #(.NUM_LIGHTS(N), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .luces(luces),
        .pos(pos_a), .locked(locked_a), .seq_err(seq_err_a),
        .lap_count(lap_a), .err_count(err_a)
    );

    light_seq_monitor #(.NUM_LIGHTS(N), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .sample_en(sample_en), .luces(luces),
        .pos(pos_b), .locked(locked_b), .seq_err(seq_err_b),
        .lap_count(lap_b), .err_count(err_b)
    );

    // free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic en, input logic [3:0] lu);
        int ones;
        int d;
        int nxt;
        ones = $countones(lu);
        d = 0;
        for (int i = 0; i < N; i++) if (lu[i]) d = i + 1;
        m_pulse = 0;
        if (!r) begin
            m_mode = 0; m_pos = 0; m_laps = 0; m_errs = 0;
        end else if (en) begin
            nxt = (m_pos == N) ? 1 : m_pos + 1;
            if (m_mode == 0) begin
                if (ones > 1) begin m_mode = 2; m_errs++; m_pulse = 1; end
                else begin m_mode = 1; m_pos = d; end
            end else if (m_mode == 1) begin
                if (ones <= 1 && d == nxt) begin
                    m_pos = d;
                    if (d == N) m_laps++;
                end else if (!(HOLD && ones <= 1 && d == m_pos)) begin
                    m_mode = 2; m_errs++; m_pulse = 1;
                end
            end else begin
                if (ones <= 1 && d <= 1) begin m_mode = 1; m_pos = d; end
            end
        end
    endtask

    task automatic check_all();
        check("pos",       int'(pos_a),     m_pos);
        check("locked",    int'(locked_a),  (m_mode == 1) ? 1 : 0);
        check("seq_err",   int'(seq_err_a), m_pulse);
        check("lap_count", int'(lap_a),     min_i(m_laps, 255));
        check("err_count", int'(err_a),     min_i(m_errs, 255));
        check("pos_w2",    int'(pos_b),     m_pos);
        check("lap_sat",   int'(lap_b),     min_i(m_laps, 3));
        check("err_sat",   int'(err_b),     min_i(m_errs, 3));
    endtask

    task automatic step(input logic r, input logic en, input logic [3:0] lu);
        @(negedge clk);
        rst = r; sample_en = en; luces = lu;
        @(posedge clk);
        model_update(r, en, lu);
        #1;
        check_all();
    endtask

    function automatic logic [3:0] onehot(input int p);
        logic [3:0] one;
        one = 4'b0001;
        return (p == 0) ? 4'b0000 : (one << (p - 1));
    endfunction

    // directed scenarios then randomized run
    initial begin
        int r;
        int nxt;
        logic [3:0] lu;
        rst = 1'b0; sample_en = 1'b0; luces = 4'b0000;

        // reset with a lit bus and sampling enabled
        step(1'b0, 1'b1, 4'b0100);
        step(1'b0, 1'b1, 4'b0100);
        check("reset_pos", int'(pos_a), 0);
        check("reset_locked", int'(locked_a), 0);

        // clean run, two laps
        step(1'b1, 1'b1, 4'b0000);
        for (int l = 0; l < 2; l++)
            for (int p = 1; p <= N; p++) step(1'b1, 1'b1, onehot(p));
        check("clean_laps", int'(lap_a), 2);

        // skip from position 2, dwell in fault, recover via L1
        step(1'b1, 1'b1, 4'b0001);
        step(1'b1, 1'b1, 4'b0010);
        step(1'b1, 1'b1, 4'b1000);
        check("skip_err", int'(seq_err_a), 1);
        check("skip_pos", int'(pos_a), 2);
        step(1'b1, 1'b1, 4'b0011);
        step(1'b1, 1'b1, 4'b0011);
        check("fault_silent", int'(seq_err_a), 0);
        step(1'b1, 1'b1, 4'b0001);
        check("recover_pos", int'(pos_a), 1);

        // repeated position
        step(1'b1, 1'b1, 4'b0010);
        step(1'b1, 1'b1, 4'b0010);
        check("repeat_err", int'(seq_err_a), HOLD ? 0 : 1);

        // five faults and five laps for counter saturation
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 4'b0000);
            step(1'b1, 1'b1, 4'b1111);
        end
        check("err_sat_direct", int'(err_b), 3);
        step(1'b1, 1'b1, 4'b0000);
        for (int l = 0; l < 5; l++)
            for (int p = 1; p <= N; p++) step(1'b1, 1'b1, onehot(p));
        check("lap_sat_direct", int'(lap_b), 3);

        // garbage while not sampling, then a clean continuation
        step(1'b1, 1'b1, 4'b0001);
        step(1'b1, 1'b1, 4'b0010);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 4'b1111);
        step(1'b1, 1'b1, 4'b0100);
        check("hold_pos", int'(pos_a), 3);

        // reset mid-lap
        step(1'b0, 1'b1, 4'b1000);
        check("midreset_laps", int'(lap_a), 0);

        // randomized traffic biased towards legal rotation
        for (int k = 0; k < 800; k++) begin
            r = $urandom_range(0, 99);
            nxt = (m_pos == N) ? 1 : m_pos + 1;
            if (r < 70)      lu = onehot(nxt);
            else if (r < 80) lu = onehot(m_pos);
            else if (r < 86) lu = 4'b0000;
            else if (r < 94) lu = 4'($urandom_range(0, 15));
            else             lu = 4'b0001;
            step(($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0, lu);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
